// File: rtl/apu_sweep_unit.sv
// Sweep unit for one NES APU pulse channel.
// Holds the $4001/$4005 sweep fields and runs the sweep divider on half-frame ticks.
// Feeds registered operands to an external carry-chain adder and turns its sum
// into the mute flag and period-reload strobes for the channel timer.
module apu_sweep_unit #(
    parameter int CHANNEL = 0
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_ce,
    input  logic        i_sweep_wr,
    input  logic [7:0]  i_sweep_data,
    input  logic        i_half_frame,
    input  logic [10:0] i_period,
    output logic [11:0] o_op_a,
    output logic [11:0] o_op_b,
    output logic        o_op_ci,
    input  logic [11:0] i_sum_in,
    output logic        o_period_load,
    output logic [10:0] o_new_period,
    output logic        o_mute
);

    // Pulse 2 negates in two's complement, so its adder gets a carry-in.
    // Pulse 1 negates in ones' complement and gets no carry-in.
    localparam logic NEG_CARRY_IN = (CHANNEL == 1);

    // Sweep register fields
    logic        r_enable;
    logic [2:0]  r_div_period;
    logic        r_negate;
    logic [2:0]  r_shift;

    // Divider and tick bookkeeping
    logic [2:0]  r_divider;
    logic        r_reload;
    logic        r_pending;

    // Operand stage
    logic [11:0] r_op_a;
    logic [11:0] r_op_b;
    logic        r_op_ci;
    logic        r_op_valid;
    logic [10:0] r_prev_period;
    logic [6:0]  r_prev_fields;

    // Outputs to the timer
    logic        r_period_load;
    logic [10:0] r_new_period;
    logic        r_mute;

    logic [6:0]  w_fields;
    logic [10:0] w_change;
    logic [11:0] w_change_ext;
    logic [11:0] w_op_b_next;
    logic        w_op_valid_next;
    logic [10:0] w_target;
    logic        w_overflow;
    logic        w_mute_next;
    logic        w_tick;
    logic        w_eval;
    logic        w_fire;

    assign w_fields        = {r_enable, r_div_period, r_negate, r_shift};
    assign w_change        = i_period >> r_shift;
    assign w_change_ext    = {1'b0, w_change};
    assign w_op_b_next     = r_negate ? ~w_change_ext : w_change_ext;
    assign w_op_valid_next = (i_period == r_prev_period) && (w_fields == r_prev_fields);

    // The adder's top bit is only a real overflow when adding; when
    // subtracting it is just the complement's carry and is ignored.
    assign w_target    = i_sum_in[10:0];
    assign w_overflow  = ~r_negate & i_sum_in[11];
    assign w_mute_next = (i_period < 11'd8) | w_overflow;

    // A tick is only acted on once the operands (and so the sum) reflect
    // the current period and fields; otherwise it is parked in r_pending.
    // A load is never issued while the previous strobe is still out, which
    // keeps strobes from landing in back-to-back ce cycles.
    assign w_tick = i_half_frame | r_pending;
    assign w_eval = w_tick & r_op_valid;
    assign w_fire = w_eval & (r_divider == 3'd0) & r_enable & (r_shift != 3'd0)
                    & ~r_mute & ~r_period_load;

    // Register adder operands and track whether they are stable enough to trust the sum.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_op_a        <= '0;
            r_op_b        <= '0;
            r_op_ci       <= 1'b0;
            r_op_valid    <= 1'b0;
            r_prev_period <= '0;
            r_prev_fields <= '0;
            r_mute        <= 1'b1;
        end else if (i_ce) begin
            r_op_a        <= {1'b0, i_period};
            r_op_b        <= w_op_b_next;
            r_op_ci       <= r_negate & NEG_CARRY_IN;
            r_op_valid    <= w_op_valid_next;
            r_prev_period <= i_period;
            r_prev_fields <= w_fields;
            r_mute        <= w_mute_next;
        end
    end

    // Sweep fields, divider and deferred tick; a write lands after the tick so it wins on reload.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_enable     <= 1'b0;
            r_div_period <= '0;
            r_negate     <= 1'b0;
            r_shift      <= '0;
            r_divider    <= '0;
            r_reload     <= 1'b0;
            r_pending    <= 1'b0;
        end else if (i_ce) begin
            if (w_tick) begin
                if (!r_op_valid) begin
                    r_pending <= 1'b1;
                end else begin
                    r_pending <= 1'b0;
                    if ((r_divider == 3'd0) || r_reload) begin
                        r_divider <= r_div_period;
                        r_reload  <= 1'b0;
                    end else begin
                        r_divider <= r_divider - 3'd1;
                    end
                end
            end
            if (i_sweep_wr) begin
                r_enable     <= i_sweep_data[7];
                r_div_period <= i_sweep_data[6:4];
                r_negate     <= i_sweep_data[3];
                r_shift      <= i_sweep_data[2:0];
                r_reload     <= 1'b1;
            end
        end
    end

    // Capture the reload strobe and the target period handed to the timer.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_period_load <= 1'b0;
            r_new_period  <= '0;
        end else if (i_ce) begin
            r_period_load <= w_fire;
            if (w_fire) begin
                r_new_period <= w_target;
            end
        end
    end

    // The strobe is gated by ce so it is seen for exactly one enabled cycle.
    assign o_period_load = r_period_load & i_ce;
    assign o_new_period  = r_new_period;
    assign o_op_a        = r_op_a;
    assign o_op_b        = r_op_b;
    assign o_op_ci       = r_op_ci;
    assign o_mute        = r_mute;

endmodule

// File: tb/tb_apu_sweep_unit.sv
// Testbench for apu_sweep_unit: one instance per pulse channel sharing all stimulus,
// each closed around its own behavioural adder. Expected period loads are queued
// when a half-frame is driven and matched against strobes as they appear.
module tb_apu_sweep_unit;

    logic        clk;
    logic        reset_n;
    logic        ce;
    logic        sweepWr;
    logic [7:0]  sweepData;
    logic        halfFrame;
    logic [10:0] period;

    logic [11:0] opA0, opB0, sum0;
    logic        opCi0, ld0, mute0;
    logic [10:0] newP0;
    logic [11:0] opA1, opB1, sum1;
    logic        opCi1, ld1, mute1;
    logic [10:0] newP1;

    logic [10:0] expQ0[$];
    logic [10:0] expQ1[$];
    logic [10:0] monExp0;
    logic [10:0] monExp1;

    int nChecks = 0;
    int nFails  = 0;

    // The downstream carry-chain adder, modelled behaviourally.
    assign sum0 = opA0 + opB0 + {11'b0, opCi0};
    assign sum1 = opA1 + opB1 + {11'b0, opCi1};

    apu_sweep_unit #(.CHANNEL(0)) dut0 (
        .i_clk(clk), .i_reset_n(reset_n), .i_ce(ce),
        .i_sweep_wr(sweepWr), .i_sweep_data(sweepData),
        .i_half_frame(halfFrame), .i_period(period),
        .o_op_a(opA0), .o_op_b(opB0), .o_op_ci(opCi0),
        .i_sum_in(sum0), .o_period_load(ld0),
        .o_new_period(newP0), .o_mute(mute0)
    );

    apu_sweep_unit #(.CHANNEL(1)) dut1 (
        .i_clk(clk), .i_reset_n(reset_n), .i_ce(ce),
        .i_sweep_wr(sweepWr), .i_sweep_data(sweepData),
        .i_half_frame(halfFrame), .i_period(period),
        .o_op_a(opA1), .o_op_b(opB1), .o_op_ci(opCi1),
        .i_sum_in(sum1), .o_period_load(ld1),
        .o_new_period(newP1), .o_mute(mute1)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison and report it if the observed value is wrong.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        nChecks++;
        if (observed !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Hold a sweep register write for one cycle.
    task automatic applySweepWrite(input logic [7:0] data);
        sweepData = data;
        sweepWr   = 1'b1;
        @(posedge clk); #1;
        sweepWr   = 1'b0;
    endtask

    // Hold a half-frame tick for one cycle.
    task automatic applyHalfFrame();
        halfFrame = 1'b1;
        @(posedge clk); #1;
        halfFrame = 1'b0;
    endtask

    // Let a number of cycles pass, ending just after a rising edge.
    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Match every period-load strobe against the queued expectations.
    always @(negedge clk) begin
        if (reset_n) begin
            if (ld0) begin
                if (expQ0.size() == 0) begin
                    checkOutput("ld0_spurious", ld0, 0);
                end else begin
                    monExp0 = expQ0.pop_front();
                    checkOutput("ld0_newp", newP0, monExp0);
                end
            end
            if (ld1) begin
                if (expQ1.size() == 0) begin
                    checkOutput("ld1_spurious", ld1, 0);
                end else begin
                    monExp1 = expQ1.pop_front();
                    checkOutput("ld1_newp", newP1, monExp1);
                end
            end
        end
    end

    // Directed sequence.
    initial begin
        reset_n   = 1'b0;
        ce        = 1'b1;
        sweepWr   = 1'b0;
        sweepData = 8'h00;
        halfFrame = 1'b0;
        period    = 11'h100;
        waitCycles(2);

        checkOutput("rst_mute0", mute0, 1);
        checkOutput("rst_ld0",   ld0,   0);
        checkOutput("rst_opa0",  opA0,  0);
        checkOutput("rst_opb0",  opB0,  0);
        checkOutput("rst_newp1", newP1, 0);
        reset_n = 1'b1;

        // Add path
        applySweepWrite(8'h81);
        waitCycles(3);
        checkOutput("add_opa0",  opA0,  12'h100);
        checkOutput("add_opb0",  opB0,  12'h080);
        checkOutput("add_opci0", opCi0, 0);
        checkOutput("add_opci1", opCi1, 0);
        checkOutput("add_mute0", mute0, 0);
        expQ0.push_back(11'h180);
        expQ1.push_back(11'h180);
        applyHalfFrame();
        waitCycles(3);

        // Negate: ones' complement on pulse 1, two's complement on pulse 2
        applySweepWrite(8'h89);
        waitCycles(3);
        checkOutput("neg_opb0",  opB0,  12'hF7F);
        checkOutput("neg_opci0", opCi0, 0);
        checkOutput("neg_opb1",  opB1,  12'hF7F);
        checkOutput("neg_opci1", opCi1, 1);
        expQ0.push_back(11'h07F);
        expQ1.push_back(11'h080);
        applyHalfFrame();
        waitCycles(3);

        // Overflow mute, then low-period mute and its boundary
        period = 11'h7FF;
        applySweepWrite(8'h81);
        waitCycles(3);
        checkOutput("ovf_mute0", mute0, 1);
        checkOutput("ovf_mute1", mute1, 1);
        applyHalfFrame();
        waitCycles(3);
        period = 11'h007;
        waitCycles(3);
        checkOutput("low7_mute0", mute0, 1);
        period = 11'h008;
        waitCycles(3);
        checkOutput("low8_mute0", mute0, 0);
        expQ0.push_back(11'h00C);
        expQ1.push_back(11'h00C);
        applyHalfFrame();
        waitCycles(3);

        // Divider P=3, with a rewrite between ticks restarting the count
        period = 11'h100;
        applySweepWrite(8'hB1);
        waitCycles(3);
        for (int t = 1; t <= 15; t++) begin
            if (t == 11) begin
                applySweepWrite(8'hB1);
                waitCycles(3);
            end
            if (t == 1 || t == 5 || t == 9 || t == 15) begin
                expQ0.push_back(11'h180);
                expQ1.push_back(11'h180);
            end
            applyHalfFrame();
            waitCycles(3);
        end

        // Reload-only tick brings the divider back to zero with P=0
        applySweepWrite(8'h81);
        waitCycles(3);
        applyHalfFrame();
        waitCycles(3);

        // Deferral: period changes, tick arrives next cycle, evaluated one cycle later
        period = 11'h200;
        @(posedge clk); #1;
        expQ0.push_back(11'h300);
        expQ1.push_back(11'h300);
        halfFrame = 1'b1;
        @(posedge clk); #1;
        halfFrame = 1'b0;
        @(negedge clk);
        checkOutput("defer_hold_ld0", ld0, 0);
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("defer_fire_ld0", ld0, 1);
        waitCycles(3);

        // Clock enable low: strobe held back and operands frozen
        expQ0.push_back(11'h300);
        expQ1.push_back(11'h300);
        halfFrame = 1'b1;
        @(posedge clk); #1;
        halfFrame = 1'b0;
        ce        = 1'b0;
        period    = 11'h300;
        @(negedge clk);
        checkOutput("ce_gate_ld0", ld0, 0);
        @(posedge clk); #1;
        checkOutput("ce_hold_opa0", opA0, 12'h200);
        period = 11'h200;
        ce     = 1'b1;
        waitCycles(3);

        // Asynchronous reset while a strobe is out
        expQ0.push_back(11'h300);
        expQ1.push_back(11'h300);
        applyHalfFrame();
        @(negedge clk); #2;
        reset_n = 1'b0;
        #1;
        checkOutput("rstld_ld0",   ld0,   0);
        checkOutput("rstld_mute0", mute0, 1);
        checkOutput("rstld_opa0",  opA0,  0);
        checkOutput("rstld_opb1",  opB1,  0);
        checkOutput("rstld_newp0", newP0, 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        waitCycles(3);

        // Asynchronous reset while a tick is pending; it must not survive
        applySweepWrite(8'h81);
        waitCycles(3);
        period = 11'h100;
        @(posedge clk); #1;
        halfFrame = 1'b1;
        @(posedge clk); #1;
        halfFrame = 1'b0;
        @(negedge clk); #2;
        reset_n = 1'b0;
        #1;
        checkOutput("rstpd_ld1",   ld1,   0);
        checkOutput("rstpd_mute1", mute1, 1);
        @(posedge clk); #1;
        reset_n = 1'b1;
        applySweepWrite(8'h81);
        waitCycles(6);

        checkOutput("q0_drained", expQ0.size(), 0);
        checkOutput("q1_drained", expQ1.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/apu_sweep_unit.md
Name: apu_sweep_unit

Overview:
- Sweep unit for one NES APU pulse channel.
- Tracks the $4001 sweep register, runs the sweep divider on half-frame ticks, and computes the mute condition.
- Drives registered operands into the downstream carry-chain period adder, which is built from the MUXCY/XORCY compatibility primitives. It consumes that adder's 12-bit sum and issues period-reload strobes to the channel timer.

Parameters:
- CHANNEL, 0, pulse channel index. 0 = pulse 1 (ones'-complement negate, carry-in 0); 1 = pulse 2 (two's-complement negate, carry-in 1).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- ce  in  1  CPU-cycle clock enable; all state except reset is qualified by ce
- sweep_wr  in  1  write strobe for $4001/$4005
- sweep_data  in  8  write data: [7] enable, [6:4] divider period P, [3] negate, [2:0] shift
- half_frame  in  1  frame-sequencer half-frame tick, one ce cycle wide
- period  in  11  current channel timer period
- op_a  out  12  adder operand A
- op_b  out  12  adder operand B
- op_ci  out  1  adder carry-in
- sum_in  in  12  sum returned combinationally from the carry-chain adder: op_a + op_b + op_ci, modulo 2^12
- period_load  out  1  one-ce-cycle strobe: timer loads new_period
- new_period  out  11  period value to load, valid while period_load = 1
- mute  out  1  channel mute from the sweep unit

Behaviour:
Reset (reset_n low, asynchronous):
- op_a, op_b, op_ci, new_period = 0; period_load = 0; mute = 1.
- Divider = 0, reload = 0, enable/P/negate/shift = 0, op_valid = 0, pending = 0.

Operand stage, every ce cycle:
- change = period >> shift.
- op_a <= {1'b0, period}.
- op_b <= negate ? ~{1'b0, change} : {1'b0, change}.
- op_ci <= negate & (CHANNEL == 1).
- op_valid <= 1 if period and the sweep fields were unchanged from the previous ce cycle, else 0.
- Operand latency is one ce cycle; sum_in is trusted only when op_valid = 1.

Derived signals:
- Target = sum_in[10:0].
- Overflow = !negate & sum_in[11]; sum_in[11] is ignored when negate = 1.
- mute <= (period < 8) | overflow, registered every ce cycle.

Half-frame processing ("tick" = half_frame | pending):
- If tick and op_valid = 0: set pending = 1 and take no other action. The tick is deferred until the operands settle.
- If tick and op_valid = 1, clear pending and:
  - If divider == 0, enable, shift != 0 and !mute: period_load = 1 for exactly one ce cycle, new_period = target.
  - Then, if divider == 0 or reload: divider <= P, reload <= 0. Otherwise divider <= divider - 1.

Writes:
- sweep_wr latches enable/P/negate/shift and sets reload = 1.

Simultaneous events:
- sweep_wr coincident with a tick: the tick is evaluated with the old fields and old divider. The write fields take effect after, and reload ends at 1 (write wins over the clear).
- At most one pending tick is held; a second tick while pending is absorbed.

Other rules:
- period_load is never asserted in two consecutive ce cycles. The timer's period change clears op_valid for the following cycle.
- ce = 0: all registers hold; period_load is held low.
- Reset mid-operation: all state returns to reset values immediately, and any pending tick or period_load strobe is discarded.

Test Plan:
- Add path: CHANNEL=0, write 0x81 (enable, P=0, shift 1), period=0x100; after settle send half_frame. Required: op_b=0x080, op_ci=0; with sum_in=0x180, period_load pulses once and new_period=0x180.
- Negate, pulse 1 vs pulse 2: write 0x89, period=0x100. CHANNEL=0 requires op_b=0xF7F, op_ci=0, and sum 0x07F loaded as new_period=0x07F. CHANNEL=1 requires op_ci=1 and new_period=0x080.
- Overflow/low-period mute: period=0x7FF, write 0x81, sum_in=0x BFE → mute=1 and no period_load on tick. period=0x007 → mute=1. Reset → mute=1.
- Divider and reload: write 0xB1 (P=3); ticks load on the 1st, then on every 4th tick (divider 3,2,1,0). A write between ticks restarts the count with reload.
- Deferral: change period in cycle N and assert half_frame in N+1. Required: pending set, evaluation in N+2 using the new period's sum, single period_load.
- Async reset: assert reset_n=0 during pending plus a period_load cycle. Required: all outputs at reset values without a clk edge; no strobe after release.
